param_mdu: RTL and testbench
============================

Name: param_mdu

Overview:
- Parametrised multiply/divide unit that replaces the fixed-latency E-stage mult/div unit.
- Owns the HI/LO registers and supports signed and unsigned mult, div, madd and msub.
- Provides mfhi/mflo/mthi/mtlo, independent configurable multiply and divide latencies, and a cancel input for pipeline flush.
- Sits in E stage beside the ALU. Its start/busy outputs feed the hazard controller, which stalls D while an MDU instruction waits.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- MUL_LAT, 5, busy cycles for mult/multu/madd/maddu/msub/msubu (must be >=1).
- DIV_LAT, 10, busy cycles for div/divu (must be >=1).
- CNT_W, 8, latency counter width (must hold max(MUL_LAT,DIV_LAT)).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- op_valid  in  1  E-stage instruction is an MDU op (qualifies op)
- op  in  4  operation code (mdu_pkg)
- cancel  in  1  flush: abort in-flight operation
- rs_data  in  WIDTH  forwarded rs operand
- rt_data  in  WIDTH  forwarded rt operand
- start  out  1  registered, high one cycle when a long op is accepted
- busy  out  1  registered, high while a long op is in flight
- result  out  WIDTH  combinational: HI for MFHI, LO for MFLO, else 0
- hi  out  WIDTH  architectural HI
- lo  out  WIDTH  architectural LO

Behaviour:
- Reset (reset low, async): hi=0, lo=0, start=0, busy=0, counter=0, pending regs=0, state IDLE.
- States: IDLE, RUN.
- Acceptance: op_valid high in cycle N, state IDLE, cancel low.
  - Long op (mult/div/madd/msub family): operands and op latched; in cycle N+1 start=1 and busy=1; counter loaded with LAT-1; state RUN.
  - MTHI/MTLO: hi/lo written at the end of cycle N; visible in N+1; start and busy stay 0.
  - MFHI/MFLO: result is valid combinationally in cycle N; no state change.
- RUN:
  - start drops after the first RUN cycle; busy stays high for exactly LAT cycles (N+1..N+LAT).
  - When the counter reaches 0, hi/lo commit at the end of cycle N+LAT; busy=0 and the new values are visible from N+LAT+1; return to IDLE.
- Arithmetic:
  - Results are computed from the latched operands, so changes on rs_data/rt_data during RUN are ignored.
  - mult/multu: {hi,lo} = 2*WIDTH-bit product, signed or unsigned.
  - madd(u)/msub(u): {hi,lo} = {hi,lo} ± product, modulo 2^(2*WIDTH). Uses the hi/lo values captured at acceptance.
  - div/divu: lo = quotient truncated toward zero; hi = remainder, with the sign of the dividend.
  - Divide by zero: hi/lo unchanged at commit; busy still runs DIV_LAT cycles.
  - Signed overflow (MIN / -1): lo=MIN, hi=0.
- op_valid while start|busy: ignored, with no state change. The hazard controller must stall; the bench flags a violation.
- MFHI/MFLO while busy: returns the old hi/lo. Preventing this is the hazard controller's responsibility.
- cancel:
  - High in any RUN cycle: pending result discarded, hi/lo unchanged; start=0, busy=0 and state IDLE next cycle.
  - High together with op_valid in IDLE: no acceptance. cancel always wins.
  - High during the commit cycle (counter=0): commit suppressed.
- op codes outside the package enum with op_valid: treated as no-op.

Decomposition:
- Package mdu_pkg:
  - localparams for op codes: MULT, MULTU, DIV, DIVU, MADD, MADDU, MSUB, MSUBU, MFHI, MFLO, MTHI, MTLO, NOP.
  - State encoding IDLE/RUN.
  - Helper is_long_op(op).
- Sub-module mdu_calc: purely combinational; computes the next {hi,lo} from the latched operands, op, and captured hi/lo.
- param_mdu keeps the FSM, counter, pending registers and HI/LO.

Test Plan:
- Reset low mid-RUN (DIV_LAT=10, cycle 4) -> start=0, busy=0, hi=0, lo=0 immediately, without waiting for a clock edge.
- MULT rs=0xFFFFFFFE (-2), rt=3, MUL_LAT=5 -> start=1 in N+1 only; busy high N+1..N+5; hi=0xFFFFFFFF, lo=0xFFFFFFFA at N+6.
- DIVU rs=7, rt=2 then MFHI/MFLO after busy falls -> lo=3, hi=1. DIV rs=-7, rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV by 0 -> hi/lo unchanged after 10 busy cycles.
- MTLO 0xFFFFFFFF, MTHI 0, then MADDU rs=1, rt=1 -> hi=1, lo=0. Then MSUBU rs=1, rt=1 -> hi=0, lo=0xFFFFFFFF.
- MULT accepted, cancel asserted in busy cycle 3 -> busy=0 next cycle, hi/lo keep prior values. cancel+op_valid same cycle in IDLE -> no start.
- op_valid MULT while busy -> ignored; the original op result commits at N+MUL_LAT. Run regressions at MUL_LAT=1, DIV_LAT=1 and WIDTH=16.

Source files
------------

// File: rtl/mdu_pkg.sv
// mdu_pkg: op codes, FSM states and op classification shared by the MDU files
package mdu_pkg;
    localparam logic [3:0] MULT  = 4'd0;
    localparam logic [3:0] MULTU = 4'd1;
    localparam logic [3:0] DIV   = 4'd2;
    localparam logic [3:0] DIVU  = 4'd3;
    localparam logic [3:0] MADD  = 4'd4;
    localparam logic [3:0] MADDU = 4'd5;
    localparam logic [3:0] MSUB  = 4'd6;
    localparam logic [3:0] MSUBU = 4'd7;
    localparam logic [3:0] MFHI  = 4'd8;
    localparam logic [3:0] MFLO  = 4'd9;
    localparam logic [3:0] MTHI  = 4'd10;
    localparam logic [3:0] MTLO  = 4'd11;
    localparam logic [3:0] NOP   = 4'd12;

    typedef enum logic {IDLE, RUN} state_t;

    // Long ops occupy the low half of the code space
    function automatic logic is_long_op(logic [3:0] op);
        return !op[3];
    endfunction

    function automatic logic is_div_op(logic [3:0] op);
        return op == DIV || op == DIVU;
    endfunction
endpackage

// File: rtl/mdu_calc.sv
// mdu_calc: combinational next {hi,lo} for a long MDU op
module mdu_calc
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] hi,
    input  logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi_n,
    output logic [WIDTH-1:0] lo_n
);
    localparam int W2 = 2 * WIDTH;

    logic             sgn, neg_a, neg_b;
    logic [W2-1:0]    ea, eb, prod, acc;
    logic [WIDTH-1:0] ua, ub, q, r;

    // Signed divide runs on magnitudes; MIN / -1 wraps back to MIN with remainder 0
    always_comb begin
        sgn   = op == MULT || op == DIV || op == MADD || op == MSUB;
        neg_a = sgn & a[WIDTH-1];
        neg_b = sgn & b[WIDTH-1];
        ea    = {{WIDTH{neg_a}}, a};
        eb    = {{WIDTH{neg_b}}, b};
        prod  = ea * eb;
        acc   = {hi, lo};
        ua    = neg_a ? -a : a;
        ub    = neg_b ? -b : b;
        q     = (ub == '0) ? '0 : ua / ub;
        r     = (ub == '0) ? '0 : ua % ub;
        {hi_n, lo_n} = acc;
        case (op)
            MULT, MULTU: {hi_n, lo_n} = prod;
            MADD, MADDU: {hi_n, lo_n} = acc + prod;
            MSUB, MSUBU: {hi_n, lo_n} = acc - prod;
            DIV, DIVU: begin
                hi_n = (b == '0) ? hi : (neg_a ? -r : r);
                lo_n = (b == '0) ? lo : ((neg_a ^ neg_b) ? -q : q);
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/param_mdu.sv
// param_mdu: multiply/divide unit with HI/LO, configurable latencies and flush
module param_mdu
    import mdu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             op_valid,
    input  logic [3:0]       op,
    input  logic             cancel,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    output logic             start,
    output logic             busy,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 1);

    state_t           state_q, state_d;
    logic             start_q, start_d, busy_q, busy_d, accept;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d, calc_hi, calc_lo;

    mdu_calc #(.WIDTH(WIDTH)) u_calc (
        .op  (op_q),
        .a   (a_q),
        .b   (b_q),
        .hi  (hi_q),
        .lo  (lo_q),
        .hi_n(calc_hi),
        .lo_n(calc_lo)
    );

    // Accept in IDLE, count down in RUN, commit on zero unless flushed
    always_comb begin
        accept  = op_valid && !cancel && state_q == IDLE;
        state_d = state_q;
        start_d = 1'b0;
        busy_d  = busy_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            IDLE: if (accept) begin
                if (is_long_op(op)) begin
                    state_d = RUN;
                    start_d = 1'b1;
                    busy_d  = 1'b1;
                    cnt_d   = is_div_op(op) ? DIV_CNT : MUL_CNT;
                    op_d    = op;
                    a_d     = rs_data;
                    b_d     = rt_data;
                end else begin
                    hi_d = (op == MTHI) ? rs_data : hi_q;
                    lo_d = (op == MTLO) ? rs_data : lo_q;
                end
            end
            RUN: if (cancel) begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end else if (cnt_q == '0) begin
                state_d = IDLE;
                busy_d  = 1'b0;
                hi_d    = calc_hi;
                lo_d    = calc_lo;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, pending operands and architectural HI/LO
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            start_q <= start_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign start  = start_q;
    assign busy   = busy_q;
    assign hi     = hi_q;
    assign lo     = lo_q;
    assign result = (op_valid && op == MFHI) ? hi_q : (op_valid && op == MFLO) ? lo_q : '0;
endmodule

// File: tb/tb_param_mdu.sv
// tb_param_mdu: directed table, flush/hazard sequences and random checks on two MDU configurations
module tb_param_mdu;
    import mdu_pkg::*;

    logic        clk, rst_n;
    logic        ov[2], cn[2];
    logic [3:0]  opc[2];
    logic [31:0] rs[2], rt[2];
    logic        start_w[2], busy_w[2];
    logic [31:0] res_w[2], hi_w[2], lo_w[2];
    logic [31:0] m_hi[2], m_lo[2];
    logic [15:0] res1, hi1, lo1;
    int          n_tests = 0, n_fail = 0;

    param_mdu #(.WIDTH(32), .MUL_LAT(5), .DIV_LAT(10), .CNT_W(8)) u0 (
        .clk(clk), .reset(rst_n), .op_valid(ov[0]), .op(opc[0]), .cancel(cn[0]),
        .rs_data(rs[0]), .rt_data(rt[0]), .start(start_w[0]), .busy(busy_w[0]),
        .result(res_w[0]), .hi(hi_w[0]), .lo(lo_w[0])
    );

    param_mdu #(.WIDTH(16), .MUL_LAT(1), .DIV_LAT(1), .CNT_W(4)) u1 (
        .clk(clk), .reset(rst_n), .op_valid(ov[1]), .op(opc[1]), .cancel(cn[1]),
        .rs_data(rs[1][15:0]), .rt_data(rt[1][15:0]), .start(start_w[1]), .busy(busy_w[1]),
        .result(res1), .hi(hi1), .lo(lo1)
    );

    assign res_w[1] = {16'h0, res1};
    assign hi_w[1]  = {16'h0, hi1};
    assign lo_w[1]  = {16'h0, lo1};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int wid(int d);
        return d == 0 ? 32 : 16;
    endfunction

    function automatic int lat(int d, logic [3:0] o);
        return (o == DIV || o == DIVU) ? (d == 0 ? 10 : 1) : (d == 0 ? 5 : 1);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: signed values as longint, {hi,lo} as a 2w-bit accumulator
    task automatic model(input int d, input logic [3:0] o, input logic [31:0] ai, input logic [31:0] bi,
                         output logic [31:0] nh, output logic [31:0] nl);
        int          w;
        bit          sg;
        logic [63:0] m, m2, a, b, acc, p, t;
        longint      sa, sb, q, r;
        w   = wid(d);
        m   = (64'd1 << w) - 64'd1;
        m2  = (w == 32) ? '1 : (64'd1 << (2 * w)) - 64'd1;
        a   = {32'h0, ai} & m;
        b   = {32'h0, bi} & m;
        sg  = o inside {MULT, DIV, MADD, MSUB};
        sa  = (sg && a[w-1]) ? longint'(a) - (longint'(1) << w) : longint'(a);
        sb  = (sg && b[w-1]) ? longint'(b) - (longint'(1) << w) : longint'(b);
        acc = ({32'h0, m_hi[d]} << w) | {32'h0, m_lo[d]};
        p   = sa * sb;
        nh  = m_hi[d];
        nl  = m_lo[d];
        t   = acc;
        if (o inside {MULT, MULTU}) t = p & m2;
        if (o inside {MADD, MADDU}) t = (acc + p) & m2;
        if (o inside {MSUB, MSUBU}) t = (acc - p) & m2;
        if (o <= MSUBU && !(o inside {DIV, DIVU})) begin
            nh = 32'((t >> w) & m);
            nl = 32'(t & m);
        end
        if (o inside {DIV, DIVU} && sb != 0) begin
            q  = sa / sb;
            r  = sa % sb;
            nl = 32'(q & m);
            nh = 32'(r & m);
        end
        if (o == MTHI) nh = 32'(a);
        if (o == MTLO) nl = 32'(a);
    endtask

    // Issue one op right after a rising edge, follow it to completion, check timing and HI/LO
    task automatic run_op(input int d, input logic [3:0] o, input logic [31:0] a, input logic [31:0] b, input bit intr);
        int          n;
        bit          extra;
        logic [31:0] eh, el;
        model(d, o, a, b, eh, el);
        ov[d] = 1'b1; opc[d] = o; rs[d] = a; rt[d] = b;
        @(posedge clk); #1;
        ov[d] = 1'b0; rs[d] = $urandom; rt[d] = $urandom;
        if (o <= MSUBU) begin
            chk("start_first", {63'h0, start_w[d]}, 64'd1);
            chk("busy_first", {63'h0, busy_w[d]}, 64'd1);
            n = 1;
            extra = 1'b0;
            while (busy_w[d] && n < 200) begin
                ov[d]  = intr && (n == 2 || n == 3);
                opc[d] = (n == 2) ? MULTU : MTHI;
                @(posedge clk); #1;
                if (busy_w[d]) begin
                    n++;
                    if (start_w[d]) extra = 1'b1;
                end
            end
            ov[d] = 1'b0;
            chk("busy_cycles", 64'(n), 64'(lat(d, o)));
            chk("start_once", {63'h0, extra}, 64'd0);
        end else begin
            chk("short_nobusy", {62'h0, start_w[d], busy_w[d]}, 64'd0);
        end
        m_hi[d] = eh;
        m_lo[d] = el;
        chk("hi", {32'h0, hi_w[d]}, {32'h0, eh});
        chk("lo", {32'h0, lo_w[d]}, {32'h0, el});
        ov[d] = 1'b1; opc[d] = MFHI; #1;
        chk("mfhi", {32'h0, res_w[d]}, {32'h0, eh});
        opc[d] = MFLO; #1;
        chk("mflo", {32'h0, res_w[d]}, {32'h0, el});
        ov[d] = 1'b0; opc[d] = NOP;
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [31:0] rs, rt, hi, lo;
    } vec_t;

    initial begin
        vec_t        tbl[14];
        logic [31:0] corner[6];
        logic [31:0] a, b;
        logic [3:0]  o;
        tbl[0]  = '{MTLO,  32'hFFFFFFFF, 32'h0,        32'h00000000, 32'hFFFFFFFF};
        tbl[1]  = '{MTHI,  32'h00000000, 32'h0,        32'h00000000, 32'hFFFFFFFF};
        tbl[2]  = '{MADDU, 32'h1,        32'h1,        32'h00000001, 32'h00000000};
        tbl[3]  = '{MSUBU, 32'h1,        32'h1,        32'h00000000, 32'hFFFFFFFF};
        tbl[4]  = '{MULT,  32'hFFFFFFFE, 32'h3,        32'hFFFFFFFF, 32'hFFFFFFFA};
        tbl[5]  = '{DIVU,  32'h7,        32'h2,        32'h00000001, 32'h00000003};
        tbl[6]  = '{DIV,   32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 32'hFFFFFFFD};
        tbl[7]  = '{DIV,   32'h5,        32'h0,        32'hFFFFFFFF, 32'hFFFFFFFD};
        tbl[8]  = '{DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        tbl[9]  = '{MADD,  32'hFFFFFFFF, 32'h2,        32'h00000000, 32'h7FFFFFFE};
        tbl[10] = '{MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        tbl[11] = '{MSUB,  32'h2,        32'h3,        32'hFFFFFFFD, 32'hFFFFFFFB};
        tbl[12] = '{MTHI,  32'h12345678, 32'h0,        32'h12345678, 32'hFFFFFFFB};
        tbl[13] = '{4'd13, 32'hDEADBEEF, 32'h1,        32'h12345678, 32'hFFFFFFFB};
        corner  = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'hFFFF8000};
        for (int d = 0; d < 2; d++) begin
            ov[d] = 1'b0; cn[d] = 1'b0; opc[d] = NOP; rs[d] = '0; rt[d] = '0;
            m_hi[d] = '0; m_lo[d] = '0;
        end
        rst_n = 1'b0;
        #3;
        for (int d = 0; d < 2; d++)
            chk("reset_state", {start_w[d], busy_w[d], hi_w[d], lo_w[d]}, 64'd0);
        #9 rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 14; i++) begin
            run_op(0, tbl[i].op, tbl[i].rs, tbl[i].rt, 1'b0);
            chk("tbl_hilo", {hi_w[0], lo_w[0]}, {tbl[i].hi, tbl[i].lo});
        end

        // Asynchronous reset in the fourth busy cycle of a divide
        ov[0] = 1'b1; opc[0] = DIV; rs[0] = 32'd100; rt[0] = 32'd7;
        @(posedge clk); #1;
        ov[0] = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk("async_reset", {start_w[0], busy_w[0], hi_w[0], lo_w[0]}, 64'd0);
        m_hi[0] = '0; m_lo[0] = '0; m_hi[1] = '0; m_lo[1] = '0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Flush in the third busy cycle
        run_op(0, MTHI, 32'hAAAA0000, 32'h0, 1'b0);
        run_op(0, MTLO, 32'h00005555, 32'h0, 1'b0);
        ov[0] = 1'b1; opc[0] = MULT; rs[0] = 32'd7; rt[0] = 32'd9;
        @(posedge clk); #1;
        ov[0] = 1'b0;
        repeat (2) @(posedge clk);
        #1 cn[0] = 1'b1;
        @(posedge clk); #1 cn[0] = 1'b0;
        chk("cancel_busy", {start_w[0], busy_w[0]}, 64'd0);
        repeat (6) @(posedge clk);
        #1 chk("cancel_hilo", {hi_w[0], lo_w[0]}, {m_hi[0], m_lo[0]});

        // Flush in the commit cycle
        ov[0] = 1'b1; opc[0] = MULTU; rs[0] = 32'd5; rt[0] = 32'd6;
        @(posedge clk); #1;
        ov[0] = 1'b0;
        repeat (4) @(posedge clk);
        #1 chk("commit_cycle_busy", {63'h0, busy_w[0]}, 64'd1);
        cn[0] = 1'b1;
        @(posedge clk); #1 cn[0] = 1'b0;
        chk("cancel_commit", {start_w[0], busy_w[0], hi_w[0], lo_w[0]}, {2'b00, m_hi[0], m_lo[0]});

        // Flush together with a new op in IDLE
        ov[0] = 1'b1; cn[0] = 1'b1; opc[0] = MULT; rs[0] = 32'd3; rt[0] = 32'd3;
        @(posedge clk); #1;
        ov[0] = 1'b0; cn[0] = 1'b0;
        chk("cancel_wins", {start_w[0], busy_w[0], hi_w[0], lo_w[0]}, {2'b00, m_hi[0], m_lo[0]});

        // Ops offered while busy are dropped
        run_op(0, MULT, 32'h00001234, 32'hFFFF5678, 1'b1);

        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 80; i++) begin
                o = 4'($urandom_range(0, 15));
                a = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
                b = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
                if ($urandom_range(0, 5) == 0) b = 32'($urandom_range(0, 3));
                run_op(d, o, a, b, 1'b0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
